// File: rtl/lcd_text_buffer.sv
// 32-entry character store feeding the 16x2 LCD display engine: decodes a byte stream
// into characters and cursor moves. Optional macro LCD_TEXT_SCROLL_EN scrolls instead of wrapping.
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iWR_DATA,
    input  logic       iWR_VALID,
    output logic       oWR_READY,
    input  logic       iCLEAR,
    input  logic [4:0] iMSG_INDEX,
    output logic [7:0] oMSG_ASCII,
    output logic [4:0] oCURSOR,
    output logic       oBUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef LCD_TEXT_SCROLL_EN
        CLEAR = 2'd1,
        SCROLL = 2'd2
`else
        CLEAR = 2'd1
`endif
    } state_t;

    logic [7:0] char_buf [32];
    state_t     state, next_state;
    logic [4:0] cursor, next_cursor;
    logic [4:0] cnt, next_cnt;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       hit_end;
`ifdef LCD_TEXT_SCROLL_EN
    logic       scroll_en;
`endif

    assign oWR_READY  = (state == IDLE) && !iCLEAR;
    assign oBUSY      = (state != IDLE);
    assign oCURSOR    = cursor;
    assign oMSG_ASCII = char_buf[iMSG_INDEX];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= IDLE;
            cursor <= 5'd0;
            cnt    <= 5'd0;
        end else begin
            state  <= next_state;
            cursor <= next_cursor;
            cnt    <= next_cnt;
        end
    end

    // The iCLEAR test ahead of the byte decode gives clear priority over a pending byte.
    always_comb begin
        next_state  = state;
        next_cursor = cursor;
        next_cnt    = cnt;
        wr_en       = 1'b0;
        wr_addr     = cursor;
        wr_data     = FILL_CHAR;
        hit_end     = 1'b0;
`ifdef LCD_TEXT_SCROLL_EN
        scroll_en   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (iCLEAR) begin
                    next_state = CLEAR;
                    next_cnt   = 5'd0;
                end else if (iWR_VALID) begin
                    if (iWR_DATA >= 8'h20 && iWR_DATA <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = iWR_DATA;
                        if (cursor == 5'd31)
                            hit_end = 1'b1;
                        else
                            next_cursor = cursor + 5'd1;
                    end else begin
                        case (iWR_DATA)
                            8'h0A: begin
                                if (!cursor[4])
                                    next_cursor = 5'd16;
                                else
                                    hit_end = 1'b1;
                            end
                            8'h08: begin
                                if (cursor != 5'd0) begin
                                    next_cursor = cursor - 5'd1;
                                    wr_en       = 1'b1;
                                    wr_addr     = cursor - 5'd1;
                                end
                            end
                            8'h0C: begin
                                next_state = CLEAR;
                                next_cnt   = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                if (cnt == 5'd31) begin
                    next_state  = IDLE;
                    next_cursor = 5'd0;
                    next_cnt    = 5'd0;
                end else begin
                    next_cnt = cnt + 5'd1;
                end
            end
`ifdef LCD_TEXT_SCROLL_EN
            SCROLL: begin
                scroll_en = 1'b1;
                if (cnt == 5'd15) begin
                    next_state  = IDLE;
                    next_cursor = 5'd16;
                    next_cnt    = 5'd0;
                end else begin
                    next_cnt = cnt + 5'd1;
                end
            end
`endif
            default: next_state = IDLE;
        endcase

        // A printable byte at the last cell is still stored before the wrap/scroll takes effect.
        if (hit_end) begin
`ifdef LCD_TEXT_SCROLL_EN
            next_state = SCROLL;
            next_cnt   = 5'd0;
`else
            next_cursor = 5'd0;
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++)
                char_buf[i] <= FILL_CHAR;
`ifdef LCD_TEXT_SCROLL_EN
        end else if (scroll_en) begin
            char_buf[{1'b0, cnt[3:0]}] <= char_buf[{1'b1, cnt[3:0]}];
            char_buf[{1'b1, cnt[3:0]}] <= FILL_CHAR;
`endif
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: table-driven byte vectors checked through a
// scoreboard queue, plus hand sequences for wrap/scroll, clear and reset-during-clear.
`timescale 1ns/1ps
module tb_lcd_text_buffer;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [7:0] iWR_DATA;
    logic       iWR_VALID;
    logic       oWR_READY;
    logic       iCLEAR;
    logic [4:0] iMSG_INDEX;
    logic [7:0] oMSG_ASCII;
    logic [4:0] oCURSOR;
    logic       oBUSY;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_cursor;
        logic [4:0] chk_idx;
        logic [7:0] exp_char;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp_cursor;
        logic [4:0] chk_idx;
        logic [7:0] exp_char;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];

    lcd_text_buffer #(.FILL_CHAR(8'h20)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iWR_DATA   (iWR_DATA),
        .iWR_VALID  (iWR_VALID),
        .oWR_READY  (oWR_READY),
        .iCLEAR     (iCLEAR),
        .iMSG_INDEX (iMSG_INDEX),
        .oMSG_ASCII (oMSG_ASCII),
        .oCURSOR    (oCURSOR),
        .oBUSY      (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_entry(input string nm, input int idx, input logic [7:0] exp);
        iMSG_INDEX = idx[4:0];
        #0.1;
        check_output($sformatf("%s[%0d]", nm, idx), {24'd0, oMSG_ASCII}, {24'd0, exp});
    endtask

    // Pops the oldest expectation once the DUT has taken the byte on the preceding edge.
    task automatic drain_one();
        exp_t e;
        e = sb_q.pop_front();
        check_output({e.name, "_cursor"}, {27'd0, oCURSOR}, {27'd0, e.exp_cursor});
        check_entry({e.name, "_char"}, int'(e.chk_idx), e.exp_char);
    endtask

    // Called at a falling edge; leaves iWR_VALID high so a following call keeps the stream back-to-back.
    task automatic apply_stimulus(input string nm, input logic [7:0] d, input logic [4:0] ec,
                                  input logic [4:0] ci, input logic [7:0] ech);
        iWR_DATA  = d;
        iWR_VALID = 1'b1;
        sb_q.push_back('{nm, ec, ci, ech});
        @(negedge iCLK);
        drain_one();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [4:0] cur;

        vecs[0] = '{8'h48, 5'd1,  5'd0,  8'h48};
        vecs[1] = '{8'h45, 5'd2,  5'd1,  8'h45};
        vecs[2] = '{8'h4C, 5'd3,  5'd2,  8'h4C};
        vecs[3] = '{8'h4C, 5'd4,  5'd3,  8'h4C};
        vecs[4] = '{8'h4F, 5'd5,  5'd4,  8'h4F};
        vecs[5] = '{8'h00, 5'd5,  5'd5,  8'h20};
        vecs[6] = '{8'h0A, 5'd16, 5'd16, 8'h20};
        vecs[7] = '{8'h41, 5'd17, 5'd16, 8'h41};
        vecs[8] = '{8'h08, 5'd16, 5'd16, 8'h20};
        vecs[9] = '{8'h08, 5'd15, 5'd15, 8'h20};

        iRST_N = 1'b0; iCLEAR = 1'b0; iWR_VALID = 1'b0; iWR_DATA = 8'h00; iMSG_INDEX = 5'd0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        #1;
        check_output("rst_cursor", {27'd0, oCURSOR}, 32'd0);
        check_output("rst_ready", {31'd0, oWR_READY}, 32'd1);
        check_output("rst_busy", {31'd0, oBUSY}, 32'd0);
        for (int i = 0; i < 32; i++) check_entry("rst_buf", i, 8'h20);

        @(negedge iCLK);
        for (int i = 0; i < 10; i++)
            apply_stimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_cursor,
                           vecs[i].chk_idx, vecs[i].exp_char);
        cur = 5'd15;
        while (cur != 5'd0) begin
            cur = cur - 5'd1;
            apply_stimulus("bksp", 8'h08, cur, cur, 8'h20);
        end
        apply_stimulus("bksp_at0", 8'h08, 5'd0, 5'd0, 8'h20);
        iWR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) check_entry("erased", i, 8'h20);

        @(negedge iCLK);
`ifdef LCD_TEXT_SCROLL_EN
        for (int i = 0; i < 31; i++)
            apply_stimulus("fill", 8'h41 + 8'(i), 5'(i + 1), 5'(i), 8'h41 + 8'(i));
        iWR_DATA = 8'h60; iWR_VALID = 1'b1;
        @(negedge iCLK);
        iWR_VALID = 1'b0;
        n = 0;
        while (oBUSY && n < 100) begin
            n++;
            @(negedge iCLK);
        end
        check_output("scroll_busy_cycles", n, 32'd16);
        check_output("scroll_cursor", {27'd0, oCURSOR}, 32'd16);
        for (int i = 0; i < 16; i++) check_entry("scroll_l1", i, 8'h51 + 8'(i));
        for (int i = 16; i < 32; i++) check_entry("scroll_l2", i, 8'h20);
        @(negedge iCLK);
`else
        for (int i = 0; i < 32; i++)
            apply_stimulus("fill", 8'h41 + 8'(i), 5'(i + 1), 5'(i), 8'h41 + 8'(i));
        apply_stimulus("wrap_Z", 8'h5A, 5'd1, 5'd0, 8'h5A);
        apply_stimulus("nl_line1", 8'h0A, 5'd16, 5'd16, 8'h51);
        apply_stimulus("nl_line2_wrap", 8'h0A, 5'd0, 5'd16, 8'h51);
        iWR_VALID = 1'b0;
        check_entry("wrap_keep", 31, 8'h60);
        @(negedge iCLK);
`endif

        // Clear request collides with a valid byte; the byte must wait out the whole clear.
        iCLEAR = 1'b1; iWR_VALID = 1'b1; iWR_DATA = 8'h55;
        #1;
        check_output("clr_ready_low", {31'd0, oWR_READY}, 32'd0);
        @(negedge iCLK);
        iCLEAR = 1'b0;
        n = 0; bad = 0;
        while (oBUSY && n < 100) begin
            n++;
            if (oWR_READY) bad++;
            @(negedge iCLK);
        end
        check_output("clr_busy_cycles", n, 32'd32);
        check_output("clr_ready_during", bad, 32'd0);
        check_output("clr_ready_after", {31'd0, oWR_READY}, 32'd1);
        @(negedge iCLK);
        iWR_VALID = 1'b0;
        check_output("held_byte_cursor", {27'd0, oCURSOR}, 32'd1);
        check_entry("held_byte", 0, 8'h55);
        for (int i = 1; i < 32; i++) check_entry("clr_buf", i, 8'h20);

        @(negedge iCLK);
        apply_stimulus("pre_rst_nl", 8'h0A, 5'd16, 5'd16, 8'h20);
        apply_stimulus("pre_rst_W", 8'h57, 5'd17, 5'd16, 8'h57);
        iWR_VALID = 1'b0;
        iCLEAR = 1'b1;
        @(negedge iCLK);
        iCLEAR = 1'b0;
        repeat (9) @(negedge iCLK);
        check_output("mid_clr_busy", {31'd0, oBUSY}, 32'd1);
        iRST_N = 1'b0;
        #1;
        check_output("async_rst_busy", {31'd0, oBUSY}, 32'd0);
        check_output("async_rst_cursor", {27'd0, oCURSOR}, 32'd0);
        check_entry("async_rst_buf", 16, 8'h20);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        check_output("post_rst_ready", {31'd0, oWR_READY}, 32'd1);
        check_output("post_rst_busy", {31'd0, oBUSY}, 32'd0);
        for (int i = 0; i < 32; i++) check_entry("post_rst_buf", i, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- 32-entry character store that feeds the 16x2 character-LCD display engine.
- Accepts a byte stream from user logic and interprets printable ASCII plus a few control codes, managing a cursor and clear/scroll sequences.
- Answers the display engine's index lookups: 0-15 is line 1, 16-31 is line 2.
- Sits directly upstream of the LCD controller: its oMSG_ASCII drives lcd_ascii, and the controller's lcd_index drives iMSG_INDEX.

Parameters:
- FILL_CHAR, 8'h20, blank character written on reset, clear, backspace and scroll.

Ports:
- iCLK  input  1  system clock (50 MHz).
- iRST_N  input  1  asynchronous active-low reset.
- iWR_DATA  input  8  character or control byte from user logic.
- iWR_VALID  input  1  iWR_DATA valid.
- oWR_READY  output  1  buffer can accept a byte this cycle.
- iCLEAR  input  1  single-cycle clear request.
- iMSG_INDEX  input  5  display-engine character index.
- oMSG_ASCII  output  8  character at iMSG_INDEX.
- oCURSOR  output  5  next write position.
- oBUSY  output  1  clear or scroll sequence in progress.

Behaviour:
- Storage: 32 x 8 flop array buf[0..31].
- Read path: oMSG_ASCII = buf[iMSG_INDEX], combinational, zero latency. Writes are visible on the read port the cycle after the clock edge.
- Reset (async, iRST_N=0):
  - every buf entry = FILL_CHAR;
  - cursor = 0, state = IDLE, clear/scroll counter = 0;
  - oBUSY = 0, oWR_READY = 1.
- States: IDLE, CLEAR, SCROLL.
- Handshake:
  - oWR_READY = (state==IDLE) && !iCLEAR.
  - A byte is consumed on a clock edge where iWR_VALID && oWR_READY.
  - iWR_DATA is ignored when no transfer occurs.
  - iCLEAR wins over a simultaneous iWR_VALID; that byte is not consumed and must be held by the source.
- Byte decode in IDLE:
  - 0x20-0x7E (printable): buf[cursor] = byte, cursor += 1. At cursor 31 the end-of-buffer rule applies.
  - 0x0A (newline): cursor 0-15 -> 16. Cursor 16-31 -> end-of-buffer rule, with no store.
  - 0x08 (backspace): if cursor > 0, cursor -= 1 and buf[new cursor] = FILL_CHAR. At cursor 0: no effect (byte still consumed).
  - 0x0C (form feed): same as iCLEAR; enter CLEAR.
  - Any other value: consumed, no effect.
- End-of-buffer rule (without scroll feature): cursor wraps to 0 (5-bit wrap); buffer contents are untouched.
- CLEAR:
  - Entered from IDLE on iCLEAR=1 or on a consumed 0x0C.
  - oBUSY = 1. One entry per cycle, buf[cnt] = FILL_CHAR for cnt 0..31: exactly 32 cycles.
  - On the cnt=31 write: cursor = 0, cnt = 0, next state IDLE.
  - oBUSY and !oWR_READY hold for exactly 32 cycles.
  - iCLEAR asserted during CLEAR or SCROLL is ignored.
- Reading during CLEAR/SCROLL is legal: each entry returns either its old or its new value.
- Reset mid-sequence: async return to reset values; the partial sequence is abandoned.

Optional Feature:
- Macro: LCD_TEXT_SCROLL_EN.
- Defined: the end-of-buffer rule enters SCROLL instead of wrapping.
  - A printable byte at cursor 31 is stored first, then SCROLL is entered.
  - A newline at cursor 16-31 enters SCROLL directly.
  - SCROLL: oBUSY = 1, 16 cycles, k = 0..15: buf[k] = buf[k+16] and buf[k+16] = FILL_CHAR in the same cycle.
  - On the k=15 write: cursor = 16, state IDLE.
  - Net effect: line 2 moves to line 1, line 2 is blanked, writing continues at the start of line 2.
- Not defined: SCROLL state and logic absent; wrap to 0 as above; oBUSY asserts only in CLEAR.

Test Plan:
- Reset -> all 32 indices read 0x20; oCURSOR=0; oWR_READY=1; oBUSY=0.
- Write "HELLO" (0x48,0x45,0x4C,0x4C,0x4F), valid held high -> one byte per cycle; index 0-4 read 'HELLO', index 5 reads 0x20, oCURSOR=5.
- From cursor 5: 0x0A then 0x41 -> buf[16]=0x41, oCURSOR=17. Then 0x08 twice, then 0x08 at 0 -> buf[16]=0x20, cursor 16 -> 15, buf[15]=0x20; repeated backspaces down to cursor 0, then one more 0x08 leaves cursor at 0 with no change.
- Write 32 chars 'A'..'`' (0x41-0x60):
  - without macro: all stored, oCURSOR=0, 33rd char 'Z' overwrites index 0;
  - with LCD_TEXT_SCROLL_EN: after the 32nd char oBUSY=1 for 16 cycles, then index 0-15 = 0x51-0x60, index 16-31 = 0x20, oCURSOR=16.
- iCLEAR pulse with iWR_VALID=1 in the same cycle -> byte not consumed; oWR_READY=0 and oBUSY=1 for exactly 32 cycles; all entries 0x20, oCURSOR=0; the held byte is consumed on the first IDLE cycle.
- Deassert iRST_N on cycle 10 of a CLEAR -> immediate reset values; after release oWR_READY=1 the next cycle; all entries read 0x20.
